histogram_divider_stage: RTL and testbench
==========================================

# histogram_divider_stage

Final stage of the histogram equalizer, downstream of the CDF stage. After `start_divider` it scans the 256-entry CDF in scratch memory for `cdf_min` and the pixel total. It then remaps every input pixel to `((cdf[p] - cdf_min) * 255) / (total - cdf_min)` using an 8-iteration sequential restoring divider, and writes the equalized 16-pixel words to output memory.

## Interface
Parameters:
- `NUM_WORDS`, 4096: 128-bit input words in the image (16 pixels per word); range 1..65535.
- `CDF_BASE`, 0: scratch-memory address of CDF word 0.
- `IN_BASE`, 0: input-memory address of image word 0.
- `OUT_BASE`, 0: output-memory address of result word 0.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start_divider` in 1: start request from master FSM; sampled only in IDLE.
- `divider_input_mem_raddr` out 16: input-memory read address.
- `divider_input_mem_rdata` in 128: pixel `i` occupies bits `[8i+7:8i]`.
- `divider_scratch_mem_raddr0` out 16: CDF read address.
- `divider_scratch_mem_rdata0` in 128: CDF word `k`, lane `j` (bits `[16j+15:16j]`) = cdf of level `8k+j`.
- `divider_output_mem_WE` out 1: one-cycle write strobe.
- `divider_output_mem_waddr` out 16: `OUT_BASE + word index`.
- `divider_output_mem_wdata` out 128: equalized pixels, same lane layout as input.
- `divider_busy` out 1: high from the cycle after start is accepted until `divider_done`.
- `divider_done` out 1: one-cycle pulse after the last write.

## Operation
- Both memories read synchronously: data is valid the cycle after the address is driven.
- States: IDLE, SCAN, CALC, RD_IN, LATCH_IN, LOOKUP, LATCH, DIV, WRITE, DONE.
- IDLE → SCAN on `start_divider`=1. `start_divider` is ignored in every other state.
- SCAN (33 cycles):
  - In SCAN cycle `k` (k=0..31), `raddr0 = CDF_BASE + k`.
  - The data for word `k` is examined in the following cycle.
  - `cdf_min` = first nonzero lane, scanning ascending level order.
  - `total` = lane 7 of word 31.
- CALC (1 cycle):
  - `denom = total - cdf_min` (16 bit).
  - Word index ← 0.
- RD_IN: drive `input_mem_raddr = IN_BASE + word index`. LATCH_IN: capture the 128-bit word; pixel index ← 0.
- LOOKUP: drive `raddr0 = CDF_BASE + pixel[7:3]`.
- LATCH:
  - Select lane `pixel[2:0]` as `c`.
  - Numerator `N = (c - cdf_min) * 255`, 24 bit.
  - `c < cdf_min` cannot occur for a pixel present in the image.
- DIV, 8 cycles, restoring division MSB-first:
  - Computes an 8-bit quotient `q`; `q` ≤ 255 is guaranteed because `N` ≤ `denom * 255` (+ `denom/2` with rounding).
  - If `denom == 0` (single-level image), `q` = original pixel (passthrough); DIV still takes 8 cycles.
  - `q` is stored into the result lane. Pixel index 15 → WRITE; otherwise increment pixel index → LOOKUP.
- WRITE:
  - `WE`=1 with `waddr = OUT_BASE + word index` and the assembled `wdata`.
  - If word index = `NUM_WORDS-1` → DONE; otherwise increment word index → RD_IN.
- DONE: `divider_done`=1 for one cycle, then → IDLE.
- Reset values: all outputs 0; FSM in IDLE; `cdf_min`, `denom`, indices and result register all 0.
- Reset mid-operation: immediate return to IDLE. The partially assembled word is discarded and never written.
- Address wrap: address arithmetic is modulo 2^16.

## Timing
- Start is sampled in cycle 0. SCAN occupies cycles 1–33; CALC is cycle 34.
- Per word: 163 cycles = RD_IN + LATCH_IN + 16 × (LOOKUP + LATCH + 8 DIV) + WRITE.
- Write of word `n` occurs in cycle `197 + 163n`.
- `divider_done` is asserted in cycle `198 + 163(NUM_WORDS-1)`.
- `divider_busy` is high in cycles 1 through the WRITE of the last word; it is low during the `divider_done` cycle.
- `divider_output_mem_WE` is never high for two consecutive cycles.
- `divider_output_mem_waddr` and `divider_output_mem_wdata` are held stable outside `WE` cycles.

## Configuration
- `DIVIDER_ROUND_EN` defined: `N` = `(c - cdf_min) * 255 + (denom >> 1)`, so the divider rounds to nearest.
- `DIVIDER_ROUND_EN` undefined: `N` = `(c - cdf_min) * 255`; the quotient truncates.
- Cycle timing is identical in both builds.

## Test plan
- `NUM_WORDS`=1; all 16 pixels 0x80; CDF 0 for levels below 128, 16 otherwise → `denom`=0; output word = all 0x80; `done` in cycle 198.
- `NUM_WORDS`=1; pixels alternating 0x00/0xFF; cdf[0..254]=8, cdf[255]=16 → output alternating 0x00/0xFF; `WE` in cycle 197 only.
- `NUM_WORDS`=1; 9 pixels at level 0, 4 at level 1, 3 at level 2; cdf = 9, 13, then 16 → level 0→0x00, level 2→0xFF; level 1→145 (0x91) without `DIVIDER_ROUND_EN`, 146 (0x92) with it.
- `NUM_WORDS`=2, `OUT_BASE`=0x100 → writes to 0x100 in cycle 197 and 0x101 in cycle 360; `done` in cycle 361; `busy` low in cycle 361.
- `start_divider` re-pulsed in cycle 50 → ignored, timing unchanged. In a separate run, assert `reset` low in cycle 120 → all outputs 0 next edge, no `WE`; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/histogram_divider_stage.sv
// histogram_divider_stage
//   Final stage of the histogram equalizer. On start it scans the 256-entry
//   CDF in scratch memory to find cdf_min (first nonzero level) and the pixel
//   total. It then remaps every input pixel p to
//     ((cdf[p] - cdf_min) * 255) / (total - cdf_min)
//   with an 8-iteration restoring divider. Results are written as 16-pixel
//   words to the output memory.
//
// Optional feature macro: DIVIDER_ROUND_EN
//   When defined, denom/2 is added to the numerator so the quotient rounds
//   to nearest. When undefined, the quotient truncates. Timing is identical.
//
// Ports
//   clock                       rising-edge clock
//   reset                       asynchronous, active-low
//   start_divider               start request, sampled only in IDLE
//   divider_input_mem_raddr     image word address (IN_BASE + word index)
//   divider_input_mem_rdata     image word, pixel i in bits [8i+7:8i]
//   divider_scratch_mem_raddr0  CDF word address (CDF_BASE + level[7:3])
//   divider_scratch_mem_rdata0  CDF word, lane j in bits [16j+15:16j]
//   divider_output_mem_WE       one-cycle write strobe
//   divider_output_mem_waddr    OUT_BASE + word index
//   divider_output_mem_wdata    equalized pixels, same lane layout as input
//   divider_busy                high from the cycle after start up to the last WRITE
//   divider_done                one-cycle pulse after the last write
//   divider_state_o             current FSM state, for observation
//
// Handshake: there is no back-pressure. Both memories answer one cycle after
// the address is presented, and the output memory accepts each WE pulse
// unconditionally.

module histogram_divider_stage #(
  parameter int unsigned NUM_WORDS = 4096,
  parameter logic [15:0] CDF_BASE  = 16'h0000,
  parameter logic [15:0] IN_BASE   = 16'h0000,
  parameter logic [15:0] OUT_BASE  = 16'h0000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_divider,
  output logic [15:0]  divider_input_mem_raddr,
  input  logic [127:0] divider_input_mem_rdata,
  output logic [15:0]  divider_scratch_mem_raddr0,
  input  logic [127:0] divider_scratch_mem_rdata0,
  output logic         divider_output_mem_WE,
  output logic [15:0]  divider_output_mem_waddr,
  output logic [127:0] divider_output_mem_wdata,
  output logic         divider_busy,
  output logic         divider_done,
  output logic [3:0]   divider_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_SCAN, S_CALC, S_RD_IN, S_LATCH_IN,
    S_LOOKUP, S_LATCH, S_DIV, S_WRITE, S_DONE
  } state_e;

  localparam logic [15:0] LAST_WORD = 16'(NUM_WORDS - 1);

  state_e       state_q;
  logic [5:0]   scan_cnt_q;
  logic         found_q;
  logic [15:0]  cdf_min_q, total_q, denom_q;
  logic [15:0]  word_idx_q;
  logic [3:0]   pix_idx_q;
  logic [127:0] in_word_q, result_q;
  logic [23:0]  rem_q, dsh_q;
  logic [7:0]   quo_q;
  logic [2:0]   div_cnt_q;
  logic [15:0]  in_raddr_q, cdf_raddr_q, waddr_q;
  logic         we_q, busy_q, done_q;
  logic [127:0] wdata_q;

  logic         scan_hit_d;
  logic [15:0]  scan_min_d;
  logic [3:0]   nxt_idx_d;
  logic [7:0]   cur_pix_d, nxt_pix_d;
  logic [15:0]  lane_c_d, diff_d;
  logic [23:0]  rnd_d, num_d;
  logic         div_ge_d;
  logic [7:0]   quo_d;

`ifdef DIVIDER_ROUND_EN
  assign rnd_d = {9'd0, denom_q[15:1]};
`else
  assign rnd_d = 24'd0;
`endif

  always_comb begin
    scan_hit_d = 1'b0;
    scan_min_d = 16'd0;
    // Descending loop: the lowest nonzero lane is the last assignment to win.
    for (int j = 7; j >= 0; j--) begin
      if (divider_scratch_mem_rdata0[16*j +: 16] != 16'd0) begin
        scan_hit_d = 1'b1;
        scan_min_d = divider_scratch_mem_rdata0[16*j +: 16];
      end
    end
    nxt_idx_d = pix_idx_q + 4'd1;
    cur_pix_d = in_word_q[{pix_idx_q, 3'b000} +: 8];
    nxt_pix_d = in_word_q[{nxt_idx_d, 3'b000} +: 8];
    lane_c_d  = divider_scratch_mem_rdata0[{cur_pix_d[2:0], 4'b0000} +: 16];
    diff_d    = lane_c_d - cdf_min_q;
    num_d     = 24'(diff_d) * 24'd255 + rnd_d;
    div_ge_d  = (rem_q >= dsh_q);
    // A single-level image has denom 0: pass the pixel through unchanged.
    quo_d     = (denom_q == 16'd0) ? cur_pix_d : {quo_q[6:0], div_ge_d};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      scan_cnt_q  <= '0;
      found_q     <= 1'b0;
      cdf_min_q   <= '0;
      total_q     <= '0;
      denom_q     <= '0;
      word_idx_q  <= '0;
      pix_idx_q   <= '0;
      in_word_q   <= '0;
      result_q    <= '0;
      rem_q       <= '0;
      dsh_q       <= '0;
      quo_q       <= '0;
      div_cnt_q   <= '0;
      in_raddr_q  <= '0;
      cdf_raddr_q <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_divider) begin
            state_q     <= S_SCAN;
            busy_q      <= 1'b1;
            scan_cnt_q  <= '0;
            found_q     <= 1'b0;
            cdf_min_q   <= '0;
            cdf_raddr_q <= CDF_BASE;
          end
        end
        S_SCAN: begin
          // Address k goes out in scan cycle k; its data arrives in cycle k+1.
          if (scan_cnt_q < 6'd31) cdf_raddr_q <= CDF_BASE + 16'(scan_cnt_q) + 16'd1;
          if (scan_cnt_q != 6'd0 && !found_q && scan_hit_d) begin
            found_q   <= 1'b1;
            cdf_min_q <= scan_min_d;
          end
          if (scan_cnt_q == 6'd32) begin
            total_q <= divider_scratch_mem_rdata0[127:112];
            state_q <= S_CALC;
          end
          scan_cnt_q <= scan_cnt_q + 6'd1;
        end
        S_CALC: begin
          denom_q    <= total_q - cdf_min_q;
          word_idx_q <= '0;
          in_raddr_q <= IN_BASE;
          state_q    <= S_RD_IN;
        end
        S_RD_IN: state_q <= S_LATCH_IN;
        S_LATCH_IN: begin
          in_word_q   <= divider_input_mem_rdata;
          pix_idx_q   <= '0;
          cdf_raddr_q <= CDF_BASE + {11'd0, divider_input_mem_rdata[7:3]};
          state_q     <= S_LOOKUP;
        end
        S_LOOKUP: state_q <= S_LATCH;
        S_LATCH: begin
          rem_q     <= num_d;
          dsh_q     <= {1'b0, denom_q, 7'd0};
          quo_q     <= '0;
          div_cnt_q <= '0;
          state_q   <= S_DIV;
        end
        S_DIV: begin
          if (div_ge_d) rem_q <= rem_q - dsh_q;
          dsh_q     <= dsh_q >> 1;
          quo_q     <= {quo_q[6:0], div_ge_d};
          div_cnt_q <= div_cnt_q + 3'd1;
          if (div_cnt_q == 3'd7) begin
            result_q[{pix_idx_q, 3'b000} +: 8] <= quo_d;
            if (pix_idx_q == 4'd15) begin
              // Lane 15 is not in result_q yet, so splice it in directly.
              we_q    <= 1'b1;
              waddr_q <= OUT_BASE + word_idx_q;
              wdata_q <= {quo_d, result_q[119:0]};
              state_q <= S_WRITE;
            end else begin
              pix_idx_q   <= nxt_idx_d;
              cdf_raddr_q <= CDF_BASE + {11'd0, nxt_pix_d[7:3]};
              state_q     <= S_LOOKUP;
            end
          end
        end
        S_WRITE: begin
          we_q <= 1'b0;
          if (word_idx_q == LAST_WORD) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            word_idx_q <= word_idx_q + 16'd1;
            in_raddr_q <= IN_BASE + word_idx_q + 16'd1;
            state_q    <= S_RD_IN;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign divider_input_mem_raddr    = in_raddr_q;
  assign divider_scratch_mem_raddr0 = cdf_raddr_q;
  assign divider_output_mem_WE      = we_q;
  assign divider_output_mem_waddr   = waddr_q;
  assign divider_output_mem_wdata   = wdata_q;
  assign divider_busy               = busy_q;
  assign divider_done               = done_q;
  assign divider_state_o            = state_q;

endmodule

// File: tb/tb_histogram_divider_stage.sv
// tb_histogram_divider_stage
//   Builds images in a model input memory, derives the CDF from the image
//   histogram, and predicts each equalized output word from the equalization
//   formula. Expected writes (data, address, cycle) are queued when a run is
//   started; a monitor pops and compares them whenever WE is seen.

module tb_histogram_divider_stage;

  localparam int          NW       = 2;
  localparam logic [15:0] CDF_BASE = 16'h0040;
  localparam logic [15:0] IN_BASE  = 16'hFFFF;
  localparam logic [15:0] OUT_BASE = 16'h0100;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start_divider = 1'b0;
  logic [15:0]  in_raddr, cdf_raddr, waddr;
  logic [127:0] in_rdata, cdf_rdata, wdata;
  logic         we, busy, done;
  logic [3:0]   state;

  histogram_divider_stage #(
    .NUM_WORDS(NW), .CDF_BASE(CDF_BASE), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_divider(start_divider),
    .divider_input_mem_raddr(in_raddr),
    .divider_input_mem_rdata(in_rdata),
    .divider_scratch_mem_raddr0(cdf_raddr),
    .divider_scratch_mem_rdata0(cdf_rdata),
    .divider_output_mem_WE(we),
    .divider_output_mem_waddr(waddr),
    .divider_output_mem_wdata(wdata),
    .divider_busy(busy),
    .divider_done(done),
    .divider_state_o(state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;

  int unsigned tick = 0;
  always @(posedge clock) tick <= tick + 1;

  // ---------------- memories (synchronous read) ----------------
  logic [127:0] in_mem  [0:65535];
  logic [127:0] cdf_mem [0:65535];
  always @(posedge clock) begin
    in_rdata  <= in_mem[in_raddr];
    cdf_rdata <= cdf_mem[cdf_raddr];
  end

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  logic [15:0]  exp_addr_q[$];
  int unsigned  exp_cyc_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int           pix [NW*16];
  logic [127:0] model_words [NW];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic         prev_we = 1'b0;
  logic [15:0]  prev_waddr = '0;
  logic [127:0] prev_wdata = '0;
  logic [127:0] mon_data;
  logic [15:0]  mon_addr;
  int unsigned  mon_cyc;

  always @(negedge clock) begin
    if (!reset) begin
      prev_we    = 1'b0;
      prev_waddr = '0;
      prev_wdata = '0;
    end else begin
      if (we) begin
        check("we_back_to_back", 128'(prev_we), 128'(1'b0));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %h data %h with nothing expected", waddr, wdata);
        end else begin
          mon_data = exp_q.pop_front();
          mon_addr = exp_addr_q.pop_front();
          mon_cyc  = exp_cyc_q.pop_front();
          check("wr_addr", 128'(waddr), 128'(mon_addr));
          check("wr_data", wdata, mon_data);
          check("wr_cycle", 128'(tick), 128'(mon_cyc));
        end
      end else begin
        check("waddr_hold", 128'(waddr), 128'(prev_waddr));
        check("wdata_hold", wdata, prev_wdata);
      end
      prev_we    = we;
      prev_waddr = waddr;
      prev_wdata = wdata;
    end
  end

  // ---------------- stimulus + reference model ----------------
  task automatic build_image(input int mode);
    int hist [256];
    int cdf  [256];
    int run, cmin, total, denom, q, a, b, base;
    bit found;
    logic [15:0]  ad;
    logic [127:0] w;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    base = $urandom_range(0, 250);
    for (int i = 0; i < NW*16; i++) begin
      case (mode)
        0: pix[i] = 8'h80;
        1: pix[i] = (i % 2 == 0) ? 0 : 255;
        2: pix[i] = ((i % 16) < 9) ? 0 : (((i % 16) < 13) ? 1 : 2);
        3: pix[i] = $urandom_range(0, 255);
        4: pix[i] = base + $urandom_range(0, 5);
        default: pix[i] = ($urandom_range(0, 1) == 1) ? a : b;
      endcase
    end
    for (int l = 0; l < 256; l++) hist[l] = 0;
    for (int i = 0; i < NW*16; i++) hist[pix[i]]++;
    run = 0;
    for (int l = 0; l < 256; l++) begin
      run += hist[l];
      cdf[l] = run;
    end
    for (int k = 0; k < 32; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(cdf[8*k+j]);
      ad = CDF_BASE + 16'(k);
      cdf_mem[ad] = w;
    end
    for (int n = 0; n < NW; n++) begin
      w = '0;
      for (int j = 0; j < 16; j++) w[8*j +: 8] = 8'(pix[16*n+j]);
      ad = IN_BASE + 16'(n);
      in_mem[ad] = w;
    end
    found = 1'b0;
    cmin  = 0;
    for (int l = 0; l < 256; l++) begin
      if (!found && cdf[l] != 0) begin
        found = 1'b1;
        cmin  = cdf[l];
      end
    end
    total = cdf[255];
    denom = total - cmin;
    for (int n = 0; n < NW; n++) begin
      w = '0;
      for (int j = 0; j < 16; j++) begin
        if (denom == 0) q = pix[16*n+j];
`ifdef DIVIDER_ROUND_EN
        else q = ((cdf[pix[16*n+j]] - cmin) * 255 + denom / 2) / denom;
`else
        else q = ((cdf[pix[16*n+j]] - cmin) * 255) / denom;
`endif
        w[8*j +: 8] = 8'(q);
      end
      model_words[n] = w;
    end
  endtask

  task automatic push_expected(input int unsigned t0);
    for (int n = 0; n < NW; n++) begin
      exp_q.push_back(model_words[n]);
      exp_addr_q.push_back(OUT_BASE + 16'(n));
      exp_cyc_q.push_back(t0 + 197 + 163 * n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},     128'(we), 128'(0));
    check({tag, "_waddr"},  128'(waddr), 128'(0));
    check({tag, "_wdata"},  wdata, 128'(0));
    check({tag, "_inaddr"}, 128'(in_raddr), 128'(0));
    check({tag, "_cdfadr"}, 128'(cdf_raddr), 128'(0));
    check({tag, "_busy"},   128'(busy), 128'(0));
    check({tag, "_done"},   128'(done), 128'(0));
    check({tag, "_state"},  128'(state), 128'(0));
  endtask

  // reset_cyc < 0: normal run. repulse_cyc: cycle in which start is raised again.
  task automatic run_image(input int repulse_cyc, input int reset_cyc);
    int unsigned t0;
    int last_wr, done_cyc, c;
    bit stop;
    last_wr  = 197 + 163 * (NW - 1);
    done_cyc = last_wr + 1;
    @(negedge clock);
    t0 = tick;
    if (reset_cyc < 0) push_expected(t0);
    start_divider = 1'b1;
    stop = 1'b0;
    c = 1;
    while (!stop) begin
      @(negedge clock);
      start_divider = (c == repulse_cyc);
      if (reset_cyc >= 0 && c == reset_cyc) begin
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("mid_reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (300) @(negedge clock);
        check("busy_after_reset", 128'(busy), 128'(0));
        stop = 1'b1;
      end else begin
        check("busy", 128'(busy), 128'(c <= last_wr));
        check("done", 128'(done), 128'(c == done_cyc));
        if (c >= done_cyc + 2) begin
          check("writes_pending", 128'(exp_q.size()), 128'(0));
          stop = 1'b1;
        end
      end
      c++;
    end
    start_divider = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      in_mem[i]  = '0;
      cdf_mem[i] = '0;
    end
    reset = 1'b0;
    start_divider = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    build_image(0); run_image(-1, -1);   // single level: passthrough
    build_image(1); run_image(50, -1);   // 0x00/0xFF extremes, ignored re-start
    build_image(2); run_image(-1, -1);   // three low levels, rounding-sensitive
    build_image(3); run_image(-1, 120);  // reset before the first write
    build_image(3); run_image(-1, -1);   // fresh start after reset
    for (int r = 0; r < 4; r++) begin
      build_image(3 + (r % 3));
      run_image(-1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
